// File: rtl/ov5640_init_pkg.sv
// Shared types and constants for the OV5640 SCCB register-table sequencer.
// Holds the state encoding, ROM entry layout and a counter-width helper.
package ov5640_init_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StWaitDone,
        StDelay,
        StNext,
        StDone,
        StErr
    } init_state_e;

    // Register address that marks a delay pseudo-command when delays are enabled
    localparam logic [15:0] DELAY_CMD_ADDR = 16'hFFFF;

    // ROM entry layout: {reg_addr[15:0], reg_data[7:0]}
    localparam int unsigned ENTRY_ADDR_MSB = 23;
    localparam int unsigned ENTRY_ADDR_LSB = 8;
    localparam int unsigned ENTRY_DATA_MSB = 7;
    localparam int unsigned ENTRY_DATA_LSB = 0;

    // Bits needed to hold values 0..max_val, never less than one
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ov5640_ms_timer.sv
// Loadable millisecond down-counter: start loads ms_count, busy stays high for
// exactly ms_count * TICKS_PER_MS cycles; clear abandons a running delay.
module ov5640_ms_timer
    import ov5640_init_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 50000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] ms_count,
    output logic       busy
);

    localparam int unsigned PRESC_W = cnt_width(TICKS_PER_MS - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_MS - 1);

    logic [PRESC_W-1:0] presc;
    logic [7:0]         ms_left;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            ms_left <= '0;
            busy    <= 1'b0;
        end else if (clear) begin
            presc   <= '0;
            ms_left <= '0;
            busy    <= 1'b0;
        end else if (start && ms_count != 8'd0) begin
            presc   <= PRESC_MAX;
            ms_left <= ms_count;
            busy    <= 1'b1;
        end else if (busy) begin
            if (presc == '0) begin
                presc   <= PRESC_MAX;
                ms_left <= ms_left - 8'd1;
                if (ms_left == 8'd1) begin
                    busy <= 1'b0;
                end
            end else begin
                presc <= presc - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ov5640_sccb_init_seq.sv
// Walks the OV5640 register ROM after power-on and issues one SCCB write per entry.
// Define OV5640_INIT_DELAY_CMD_EN to treat 16'hFFFF entries as millisecond delays.
module ov5640_sccb_init_seq
    import ov5640_init_pkg::*;
#(
    parameter int unsigned REG_NUM     = 252,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             initial_en,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [23:0]      rom_data,
    output logic             sccb_req,
    input  logic             sccb_ack,
    output logic [15:0]      sccb_addr,
    output logic [7:0]       sccb_data,
    input  logic             sccb_done,
    input  logic             sccb_nack,
    output logic [IDX_W-1:0] reg_index,
    output logic             init_done,
    output logic             init_err
);

    localparam int unsigned        RETRY_W     = cnt_width(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(REG_NUM - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    if ((2 ** IDX_W) < REG_NUM || CLK_FREQ_HZ < 1000) begin : g_param_check
        $error("ov5640_sccb_init_seq: IDX_W too small for REG_NUM or CLK_FREQ_HZ below 1 kHz");
    end

    init_state_e        state;
    logic               initial_en_q;
    logic [IDX_W-1:0]   idx;
    logic [RETRY_W-1:0] retry;
    logic               start;
    logic               abort;
    logic               can_retry;
    logic [15:0]        entry_addr;
    logic [7:0]         entry_data;

    assign entry_addr = rom_data[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
    assign entry_data = rom_data[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
    assign start      = initial_en & ~initial_en_q;
    assign abort      = ~initial_en & (state != StIdle);
    assign can_retry  = retry < RETRY_LIMIT;
    assign reg_index  = idx;

`ifdef OV5640_INIT_DELAY_CMD_EN
    logic is_delay;
    logic timer_start;
    logic timer_busy;

    assign is_delay    = entry_addr == DELAY_CMD_ADDR;
    assign timer_start = (state == StLatch) & is_delay & ~abort;

    ov5640_ms_timer #(
        .TICKS_PER_MS (CLK_FREQ_HZ / 1000)
    ) u_ms_timer (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .clear    (abort),
        .start    (timer_start),
        .ms_count (entry_data),
        .busy     (timer_busy)
    );
`endif

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            // A level already high out of reset is not a start; a 0->1 edge must be seen
            initial_en_q <= 1'b1;
            idx          <= '0;
            retry        <= '0;
            rom_addr     <= '0;
            sccb_req     <= 1'b0;
            sccb_addr    <= '0;
            sccb_data    <= '0;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
        end else begin
            initial_en_q <= initial_en;
            if (abort) begin
                state     <= StIdle;
                sccb_req  <= 1'b0;
                init_done <= 1'b0;
                init_err  <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        rom_addr <= '0;
                        idx      <= '0;
                        retry    <= '0;
                        sccb_req <= 1'b0;
                        if (start) begin
                            state <= StFetch;
                        end
                    end
                    StFetch: begin
                        rom_addr <= idx;
                        state    <= StLatch;
                    end
                    StLatch: begin
`ifdef OV5640_INIT_DELAY_CMD_EN
                        if (is_delay) begin
                            state <= (entry_data == 8'd0) ? StNext : StDelay;
                        end else
`endif
                        begin
                            sccb_addr <= entry_addr;
                            sccb_data <= entry_data;
                            sccb_req  <= 1'b1;
                            state     <= StIssue;
                        end
                    end
                    StIssue: begin
                        // ack and done together behave as ack followed by done
                        if (sccb_ack) begin
                            if (!sccb_done) begin
                                sccb_req <= 1'b0;
                                state    <= StWaitDone;
                            end else if (!sccb_nack) begin
                                sccb_req <= 1'b0;
                                state    <= StNext;
                            end else if (can_retry) begin
                                retry <= retry + 1'b1;
                            end else begin
                                sccb_req <= 1'b0;
                                init_err <= 1'b1;
                                state    <= StErr;
                            end
                        end
                    end
                    StWaitDone: begin
                        if (sccb_done) begin
                            if (!sccb_nack) begin
                                state <= StNext;
                            end else if (can_retry) begin
                                retry    <= retry + 1'b1;
                                sccb_req <= 1'b1;
                                state    <= StIssue;
                            end else begin
                                init_err <= 1'b1;
                                state    <= StErr;
                            end
                        end
                    end
`ifdef OV5640_INIT_DELAY_CMD_EN
                    StDelay: begin
                        if (!timer_busy) begin
                            state <= StNext;
                        end
                    end
`endif
                    StNext: begin
                        retry <= '0;
                        if (idx == LAST_IDX) begin
                            init_done <= 1'b1;
                            state     <= StDone;
                        end else begin
                            idx      <= idx + 1'b1;
                            rom_addr <= idx + 1'b1;
                            state    <= StFetch;
                        end
                    end
                    StDone, StErr: begin
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov5640_sccb_init_seq.sv
// Directed bench for ov5640_sccb_init_seq: table of master behaviours plus
// hand-written abort, reset and delay-entry sequences.
module tb_ov5640_sccb_init_seq;

    localparam int unsigned REG_NUM   = 4;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned CLK_HZ    = 1000000;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TICKS     = CLK_HZ / 1000;

    logic             clk_50M = 1'b0;
    logic             reset;
    logic             initial_en;
    logic [IDX_W-1:0] rom_addr;
    logic [23:0]      rom_data;
    logic             sccb_req;
    logic             sccb_ack;
    logic [15:0]      sccb_addr;
    logic [7:0]       sccb_data;
    logic             sccb_done;
    logic             sccb_nack;
    logic [IDX_W-1:0] reg_index;
    logic             init_done;
    logic             init_err;

    ov5640_sccb_init_seq #(
        .REG_NUM     (REG_NUM),
        .IDX_W       (IDX_W),
        .CLK_FREQ_HZ (CLK_HZ),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .initial_en (initial_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_req   (sccb_req),
        .sccb_ack   (sccb_ack),
        .sccb_addr  (sccb_addr),
        .sccb_data  (sccb_data),
        .sccb_done  (sccb_done),
        .sccb_nack  (sccb_nack),
        .reg_index  (reg_index),
        .init_done  (init_done),
        .init_err   (init_err)
    );

    always #10 clk_50M = ~clk_50M;

    // Synchronous ROM, one cycle read latency
    logic [23:0] rom [4];
    always @(posedge clk_50M) rom_data <= rom[rom_addr[1:0]];

    // SCCB master model: acks one cycle after seeing req, done cfg_lat cycles later
    int          cycle_n;
    logic [23:0] log_mem [64];
    int          log_time [64];
    int          log_wr;
    int          cfg_gen;
    int          cfg_nack_times;
    int          cfg_lat;
    logic [15:0] cfg_nack_addr;

    initial begin : master
        int seen_gen;
        int nack_seen;
        int cnt;
        bit busy;
        bit req_wait;
        bit pend_nack;
        seen_gen = 0; nack_seen = 0; cnt = 0; busy = 0; req_wait = 0; pend_nack = 0;
        cycle_n = 0; log_wr = 0;
        sccb_ack = 0; sccb_done = 0; sccb_nack = 0;
        forever begin
            @(negedge clk_50M);
            cycle_n++;
            if (cfg_gen != seen_gen) begin
                seen_gen  = cfg_gen;
                nack_seen = 0;
            end
            sccb_ack = 0; sccb_done = 0; sccb_nack = 0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    sccb_done = 1;
                    sccb_nack = pend_nack;
                    busy      = 0;
                end
            end else if (sccb_req) begin
                if (req_wait) begin
                    sccb_ack = 1;
                    req_wait = 0;
                    if (log_wr < 64) begin
                        log_mem[log_wr]  = {sccb_addr, sccb_data};
                        log_time[log_wr] = cycle_n;
                        log_wr++;
                    end
                    pend_nack = (sccb_addr == cfg_nack_addr) && (nack_seen < cfg_nack_times);
                    if (pend_nack) nack_seen++;
                    if (cfg_lat == 0) begin
                        sccb_done = 1;
                        sccb_nack = pend_nack;
                    end else begin
                        busy = 1;
                        cnt  = cfg_lat;
                    end
                end else begin
                    req_wait = 1;
                end
            end else begin
                req_wait = 0;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic wait_flags(input string name, input int limit);
        int k = 0;
        while (!(init_done || init_err) && k < limit) begin
            @(negedge clk_50M);
            k++;
        end
        check({name, " finished in time"}, longint'(init_done | init_err), 1);
    endtask

    task automatic wait_log(input string name, input int target, input int limit);
        int k = 0;
        while (log_wr < target && k < limit) begin
            @(negedge clk_50M);
            k++;
        end
        check({name, " writes reached"}, longint'(log_wr >= target), 1);
    endtask

    task automatic count_req(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk_50M);
            if (sccb_req) c++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " rom_addr"}, rom_addr, 0);
        check({name, " sccb_req"}, sccb_req, 0);
        check({name, " sccb_addr"}, sccb_addr, 0);
        check({name, " sccb_data"}, sccb_data, 0);
        check({name, " reg_index"}, reg_index, 0);
        check({name, " init_done"}, init_done, 0);
        check({name, " init_err"}, init_err, 0);
    endtask

    task automatic set_master(input int nack_entry, input int nack_times, input int lat);
        cfg_nack_addr  = rom[nack_entry][23:8];
        cfg_nack_times = nack_times;
        cfg_lat        = lat;
        cfg_gen++;
    endtask

    // seq lists the ROM entry of each expected write, first write in the low nibble
    typedef struct {
        string       name;
        int          nack_entry;
        int          nack_times;
        int          lat;
        int          len;
        logic [31:0] seq;
        int          exp_done;
        int          exp_err;
        int          exp_index;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        int c;
        vecs[0] = '{"plain",        0, 0,  10, 4, 32'h0000_3210,   1, 0, 3};
        vecs[1] = '{"nack1x2",      1, 2,  10, 6, 32'h0032_1110,   1, 0, 3};
        vecs[2] = '{"nack2always",  2, 99, 10, 6, 32'h0022_2210,   0, 1, 2};
        vecs[3] = '{"ackdone_same", 0, 0,  0,  4, 32'h0000_3210,   1, 0, 3};
        vecs[4] = '{"nack3x3",      3, 3,  10, 7, 32'h0333_3210,   1, 0, 3};

        rom[0] = 24'h300882; rom[1] = 24'h310303; rom[2] = 24'h3017FF; rom[3] = 24'h3018FF;
        cfg_gen = 0; cfg_nack_addr = 16'h0; cfg_nack_times = 0; cfg_lat = 10;
        reset = 1'b1;
        initial_en = 1'b0;
        cycles(2);
        check_reset_outputs("reset");
        reset = 1'b0;
        cycles(3);

        for (int v = 0; v < 5; v++) begin
            set_master(vecs[v].nack_entry, vecs[v].nack_times, vecs[v].lat);
            initial_en = 1'b0;
            @(negedge clk_50M);
            check({vecs[v].name, " abort clears req/done/err"},
                  {sccb_req, init_done, init_err}, 0);
            cycles(3);
            base = log_wr;
            initial_en = 1'b1;
            wait_flags(vecs[v].name, 3000);
            cycles(40);
            check({vecs[v].name, " write count"}, log_wr - base, vecs[v].len);
            for (int i = 0; i < vecs[v].len; i++) begin
                check($sformatf("%s write %0d", vecs[v].name, i), log_mem[base + i],
                      rom[int'(vecs[v].seq[4*i +: 4])]);
            end
            check({vecs[v].name, " init_done"}, init_done, vecs[v].exp_done);
            check({vecs[v].name, " init_err"}, init_err, vecs[v].exp_err);
            check({vecs[v].name, " reg_index"}, reg_index, vecs[v].exp_index);
        end

        // Abort while entry 1 waits for done, restart 20 cycles later
        set_master(0, 0, 10);
        initial_en = 1'b0;
        cycles(3);
        base = log_wr;
        initial_en = 1'b1;
        wait_log("abort", base + 2, 500);
        cycles(3);
        initial_en = 1'b0;
        @(negedge clk_50M);
        check("abort req low", sccb_req, 0);
        check("abort flags", {init_done, init_err}, 0);
        @(negedge clk_50M);
        check("abort reg_index cleared", reg_index, 0);
        count_req(18, c);
        check("abort idle no req", c, 0);
        base = log_wr;
        initial_en = 1'b1;
        wait_flags("restart", 3000);
        cycles(40);
        check("restart write count", log_wr - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("restart write %0d", i), log_mem[base + i], rom[i]);
        end
        check("restart init_done", init_done, 1);

        // Delay pseudo-command in entry 1
        rom[1] = 24'hFFFF02;
        set_master(0, 0, 10);
        initial_en = 1'b0;
        cycles(3);
        base = log_wr;
        initial_en = 1'b1;
        wait_flags("delay", 3 * TICKS + 2000);
        cycles(40);
`ifdef OV5640_INIT_DELAY_CMD_EN
        check("delay write count", log_wr - base, 3);
        check("delay write 0", log_mem[base], rom[0]);
        check("delay write 1 is entry 2", log_mem[base + 1], rom[2]);
        check("delay write 2 is entry 3", log_mem[base + 2], rom[3]);
        check_near("delay gap", log_time[base + 1] - log_time[base], 2 * TICKS + 19, 2);
`else
        check("ffff write count", log_wr - base, 4);
        check("ffff written as register", log_mem[base + 1], 24'hFFFF02);
        check("ffff next write", log_mem[base + 2], rom[2]);
`endif
        check("delay init_done", init_done, 1);
        rom[1] = 24'h310303;

        // initial_en high across reset release is not a start
        set_master(0, 0, 10);
        reset = 1'b1;
        initial_en = 1'b1;
        cycles(3);
        reset = 1'b0;
        count_req(30, c);
        check("no edge no req", c, 0);
        check("no edge init_done", init_done, 0);
        initial_en = 1'b0;
        cycles(2);
        base = log_wr;
        initial_en = 1'b1;
        wait_log("midreset", base + 2, 500);
        cycles(2);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        cycles(3);
        reset = 1'b0;
        count_req(30, c);
        check("after reset no req", c, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
